// File: rtl/universal_add_sub_if.sv
// Operand/result bundle for the registered add/subtract primitive.
// The master drives the operands and mode; the slave returns the registered result and flags.
interface universal_add_sub_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             MODE;
    logic [WIDTH-1:0] Result;
    logic             Cout;
    logic             Overflow;

    modport master (
        output A,
        output B,
        output MODE,
        input  Result,
        input  Cout,
        input  Overflow
    );

    modport slave (
        input  A,
        input  B,
        input  MODE,
        output Result,
        output Cout,
        output Overflow
    );
endinterface

// File: rtl/universal_add_sub.sv
// Registered two's-complement adder/subtractor built from a ripple-carry chain.
// MODE=1 inverts B and injects a carry-in, so the chain computes A + ~B + 1.
module universal_add_sub #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    universal_add_sub_if.slave  io_bus
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_carry;

    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_overflow;

    always_comb begin
        w_b_eff    = io_bus.B ^ {WIDTH{io_bus.MODE}};
        w_sum      = '0;
        w_carry    = '0;
        w_carry[0] = io_bus.MODE;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum[i]       = io_bus.A[i] ^ w_b_eff[i] ^ w_carry[i];
            w_carry[i + 1] = (io_bus.A[i] & w_b_eff[i]) | (io_bus.A[i] & w_carry[i]) |
                             (w_b_eff[i] & w_carry[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_result   <= w_sum;
            r_cout     <= w_carry[WIDTH];
            // Signed overflow: carry into the MSB disagrees with carry out of it.
            r_overflow <= w_carry[WIDTH] ^ w_carry[WIDTH - 1];
        end
    end

    assign io_bus.Result   = r_result;
    assign io_bus.Cout     = r_cout;
    assign io_bus.Overflow = r_overflow;

endmodule

// File: tb/tb_universal_add_sub.sv
// Scoreboard bench for universal_add_sub: directed corner vectors, reset behaviour and
// 1000 random cycles checked one cycle after they are driven.
module tb_universal_add_sub;

    localparam int unsigned WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst;

    universal_add_sub_if #(.WIDTH(WIDTH)) u_bus ();

    universal_add_sub #(.WIDTH(WIDTH)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (u_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb_q[$];
    exp_t        prev_exp;
    bit          prev_valid;
    int unsigned n_vec;
    int unsigned n_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference from integer arithmetic rather than a carry chain.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic mode);
        exp_t e;
        int   ua, ub, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = $signed(a);
        sb = $signed(b);
        if (mode) begin
            e.res  = a - b;
            e.cout = (ua >= ub);
            sr     = sa - sb;
        end else begin
            e.res  = a + b;
            e.cout = ((ua + ub) > 15);
            sr     = sa + sb;
        end
        e.ovf = (sr > 7) || (sr < -8);
        return e;
    endfunction

    // Drive one vector at the falling edge and check its result just after the next rising edge.
    task automatic apply(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic mode, input exp_t e);
        exp_t got;
        @(negedge clk);
        u_bus.A    = a;
        u_bus.B    = b;
        u_bus.MODE = mode;
        sb_q.push_back(e);
        #1;
        if (prev_valid)
            check_val({tag, "_hold"}, {26'd0, u_bus.Result, u_bus.Cout, u_bus.Overflow},
                      {26'd0, prev_exp});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check_val(tag, {26'd0, u_bus.Result, u_bus.Cout, u_bus.Overflow}, {26'd0, got});
            prev_exp   = got;
            prev_valid = 1'b1;
        end
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] r, input logic c, input logic v);
        exp_t e;
        e.res  = r;
        e.cout = c;
        e.ovf  = v;
        return e;
    endfunction

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rm;
        n_vec      = 0;
        n_err      = 0;
        prev_valid = 1'b0;
        rst        = 1'b1;
        u_bus.A    = 4'b0101;
        u_bus.B    = 4'b0011;
        u_bus.MODE = 1'b0;

        #1;
        check_val("reset_t0", {26'd0, u_bus.Result, u_bus.Cout, u_bus.Overflow}, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_val("reset_hold", {26'd0, u_bus.Result, u_bus.Cout, u_bus.Overflow}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        apply("add_5p3",    4'b0101, 4'b0011, 1'b0, mk(4'b1000, 1'b0, 1'b1));
        apply("add_7p4",    4'b0111, 4'b0100, 1'b0, mk(4'b1011, 1'b0, 1'b1));
        apply("sub_9m3",    4'b1001, 4'b0011, 1'b1, mk(4'b0110, 1'b1, 1'b1));
        apply("sub_borrow", 4'b0100, 4'b0110, 1'b1, mk(4'b1110, 1'b0, 1'b0));
        apply("add_7p7",    4'b0111, 4'b0111, 1'b0, mk(4'b1110, 1'b0, 1'b1));
        apply("add_wrap",   4'b1111, 4'b0001, 1'b0, mk(4'b0000, 1'b1, 1'b0));
        apply("sub_equal",  4'b1010, 4'b1010, 1'b1, mk(4'b0000, 1'b1, 1'b0));
        apply("sub_zero",   4'b0000, 4'b0000, 1'b1, mk(4'b0000, 1'b1, 1'b0));
        apply("sub_minneg", 4'b1000, 4'b0001, 1'b1, mk(4'b0111, 1'b1, 1'b1));

        // Mid-cycle reset with nonzero outputs must clear them at once and hold them clear.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("reset_async", {26'd0, u_bus.Result, u_bus.Cout, u_bus.Overflow}, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_val("reset_edges", {26'd0, u_bus.Result, u_bus.Cout, u_bus.Overflow}, 32'd0);
        end
        @(negedge clk);
        rst        = 1'b0;
        prev_valid = 1'b0;

        apply("post_reset", 4'b0011, 4'b0010, 1'b0, mk(4'b0101, 1'b0, 1'b0));

        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom_range(0, 15));
            rb = WIDTH'($urandom_range(0, 15));
            rm = 1'($urandom_range(0, 1));
            apply("random", ra, rb, rm, model(ra, rb, rm));
        end

        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/universal_add_sub.md
Name: universal_add_sub

Overview:
Registered two's-complement adder/subtractor with a MODE select. It produces a WIDTH-bit result, an unsigned carry/no-borrow flag and a signed overflow flag. It serves as the arithmetic primitive in datapath/ALU blocks, with all outputs registered on one clock.

Parameters:
WIDTH, 4, operand and result width in bits (minimum 2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
A  input  WIDTH  operand A
B  input  WIDTH  operand B
MODE  input  1  0 = add (A+B), 1 = subtract (A-B)
Result  output  WIDTH  registered sum/difference, modulo 2^WIDTH
Cout  output  1  registered carry out of MSB
Overflow  output  1  registered signed-overflow flag

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- While rst is high: Result=0, Cout=0, Overflow=0 immediately, independent of clk. Release is synchronous in effect: the first update is at the first rising clk edge after rst falls.
- Datapath structure: ripple-carry chain of WIDTH full adders.
  - Operand B goes through a per-bit XOR with MODE (B ^ {WIDTH{MODE}}).
  - Carry-in is MODE, so subtraction is A + ~B + 1.
- Arithmetic rules:
  - sum = A + (B^MODE) + MODE, computed in WIDTH+1 bits.
  - Result = low WIDTH bits of sum.
  - Cout = carry out of bit WIDTH-1.
- Cout meaning:
  - Add: 1 means unsigned overflow.
  - Subtract: 1 means no borrow (A >= B unsigned); 0 means borrow.
- Overflow = carry into MSB XOR carry out of MSB. This is equivalent to the operands (after B inversion) having the same sign while Result has a different sign.
- Latency: exactly 1 cycle.
  - Inputs are sampled at every rising clk edge; no enable, no handshake.
  - Outputs reflect the inputs sampled at the most recent edge and are held stable between edges.
  - No combinational path from inputs to outputs.
- MODE may change on any cycle. Each cycle's result depends only on that cycle's sampled A, B, MODE; no internal state beyond the output registers.
- Wrap-around: Result silently wraps modulo 2^WIDTH. Flags report the condition; nothing saturates.
- Boundary cases:
  - A-B with A==B: Result=0, Cout=1, Overflow=0.
  - 0-0: Result=0, Cout=1.
  - Most-negative minus 1 (1000-0001): Result=0111, Overflow=1, Cout=1.
- X/unknown inputs need no defined handling; the outputs simply propagate them.

Test Plan:
- Reset: assert rst mid-cycle with nonzero outputs -> Result=0, Cout=0, Overflow=0 immediately; remain 0 through clock edges until rst deasserts.
- Add, WIDTH=4: MODE=0, A=0101, B=0011 -> next edge Result=1000, Cout=0, Overflow=1. Then A=0111, B=0100 -> Result=1011, Cout=0, Overflow=1.
- Subtract: MODE=1, A=1001, B=0011 -> Result=0110, Cout=1, Overflow=1. Then A=0100, B=0110 -> Result=1110, Cout=0 (borrow), Overflow=0.
- Signed-overflow add: MODE=0, A=0111, B=0111 -> Result=1110, Cout=0, Overflow=1. Also A=1111, B=0001 -> Result=0000, Cout=1, Overflow=0.
- Subtract boundaries: A=B=1010 -> Result=0000, Cout=1, Overflow=0. A=1000, B=0001 -> Result=0111, Cout=1, Overflow=1.
- Latency/randomized: random A, B, MODE every cycle for 1000 cycles. Compare against the reference model delayed one cycle; outputs must not change between clock edges.
